// File: rtl/add128_carry_merge.sv
// Carry-merge back end of the parallel 128-bit adder: folds the inter-slice carry
// chain into a backpressured pipeline, SPS slices resolved per registered stage.
module add128_carry_merge #(
  parameter int NSLICE  = 16,
  parameter int SLICE_W = 8,
  parameter int SPS     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NSLICE*(SLICE_W+1)-1:0]     part_sum,
  input  logic                              cin,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NSLICE*SLICE_W-1:0]         sum,
  output logic                              cout
);

  localparam int PW    = SLICE_W + 1;
  localparam int DEPTH = NSLICE / SPS;

  // Adds the incoming carry into one slice; returns {carry_out, slice_sum}.
  function automatic logic [PW-1:0] resolve_slice(input logic [PW-1:0] part, input logic carry);
    logic [SLICE_W-1:0] s;
    logic               co;
    s  = part[SLICE_W-1:0] + {{(SLICE_W-1){1'b0}}, carry};
    co = part[SLICE_W] | ((&part[SLICE_W-1:0]) & carry);
    return {co, s};
  endfunction

  logic [DEPTH-1:0] load_s;
  logic [DEPTH-1:0] v_s;

  // Stage k may load when empty or when everything downstream of it moves.
  always_comb begin
    load_s            = '0;
    load_s[DEPTH-1]   = ~v_s[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      load_s[k] = ~v_s[k] | load_s[k+1];
    end
  end

  assign in_ready  = rst_n & load_s[0];
  assign out_valid = v_s[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam int LO   = k * SPS;
    localparam int HI   = LO + SPS;
    localparam int NSRC = NSLICE - LO;

    logic [NSRC*PW-1:0]      src_part_s;
    logic                    src_carry_s;
    logic                    src_valid_s;
    logic [SPS*SLICE_W-1:0]  res_s;
    logic [SPS:0]            chain_s;
    logic [HI*SLICE_W-1:0]   sum_next_s;
    logic [HI*SLICE_W-1:0]   sum_r;
    logic                    carry_r;
    logic                    v_r;

    if (k == 0) begin : g_src
      assign src_part_s  = part_sum;
      assign src_carry_s = cin;
      assign src_valid_s = in_valid;
      assign sum_next_s  = res_s;
    end else begin : g_src
      assign src_part_s  = g_stage[k-1].g_up.part_r;
      assign src_carry_s = g_stage[k-1].carry_r;
      assign src_valid_s = v_s[k-1];
      assign sum_next_s  = {res_s, g_stage[k-1].sum_r};
    end

    assign chain_s[0] = src_carry_s;
    for (genvar j = 0; j < SPS; j++) begin : g_slice
      assign {chain_s[j+1], res_s[j*SLICE_W +: SLICE_W]} =
        resolve_slice(src_part_s[j*PW +: PW], chain_s[j]);
    end

    assign v_s[k] = v_r;

    // Stage register: valid follows the upstream on every load, payload only on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r     <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (load_s[k]) begin
        v_r <= src_valid_s;
        if (src_valid_s) begin
          carry_r <= chain_s[SPS];
          sum_r   <= sum_next_s;
        end
      end
    end

    if (k < DEPTH - 1) begin : g_up
      localparam int NUP = NSLICE - HI;
      logic [NUP*PW-1:0] part_r;

      // Unresolved upper partials travel alongside the running carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          part_r <= '0;
        end else if (load_s[k] && src_valid_s) begin
          part_r <= src_part_s[NSRC*PW-1:SPS*PW];
        end
      end
    end else begin : g_out
      assign sum  = sum_r;
      assign cout = carry_r;
    end
  end

endmodule

// File: tb/tb_add128_carry_merge.sv
// Scoreboard bench for add128_carry_merge: expected A+B+cin queued on accept,
// checked in order as results leave under various backpressure patterns.
module tb_add128_carry_merge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [143:0] part_sum;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] sum;
  logic         cout;

  int           vectors = 0;
  int           errs = 0;
  logic [128:0] exp_q[$];
  int           run_len = 0;
  int           max_run = 0;
  bit           stall_prev = 1'b0;
  logic [128:0] held = '0;
  bit           done;

  localparam logic [127:0] ONES = {128{1'b1}};

  always #5 clk = ~clk;

  add128_carry_merge dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .part_sum(part_sum), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  task automatic check_eq(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] mk_part(input logic [127:0] a, input logic [127:0] b);
    logic [143:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      p[i*9 +: 9] = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
    end
    return p;
  endfunction

  function automatic logic [128:0] model(input logic [127:0] a, input logic [127:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {128'd0, c};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One offer cycle: present the op, note acceptance at the following edge.
  task automatic offer(input logic [127:0] a, input logic [127:0] b, input logic c, output bit took);
    part_sum = mk_part(a, b);
    cin      = c;
    in_valid = 1'b1;
    @(negedge clk);
    took = in_ready;
    if (took) exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_op(input logic [127:0] a, input logic [127:0] b, input logic c);
    bit took;
    for (int i = 0; i < 200; i++) begin
      offer(a, b, c, took);
      if (took) return;
    end
    check_eq("accept_timeout", {128'd0, in_ready}, 129'd1);
  endtask

  task automatic single_op(input logic [127:0] a, input logic [127:0] b, input logic c, input string tag);
    out_ready = 1'b1;
    drive_op(a, b, c);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_eq({tag, "_latency"}, {128'd0, out_valid}, {128'd0, (n == 3)});
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge rst_n) stall_prev = 1'b0;

  // Output monitor: scoreboard pops, stall stability and run length.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      run_len    = 0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", {128'd0, out_valid}, 129'd1);
        check_eq("stall_data", {cout, sum}, held);
      end
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_output", {128'd0, out_valid}, 129'd0);
        else check_eq("result", {cout, sum}, exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      held       = {cout, sum};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] a_arr[6];
    logic [127:0] b_arr[6];
    logic         c_arr[6];
    int           n;
    bit           took;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; part_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {128'd0, out_valid}, 129'd0);
    check_eq("rst_in_ready", {128'd0, in_ready}, 129'd0);
    check_eq("rst_sum", {cout, sum}, 129'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_after_rst", {128'd0, in_ready}, 129'd1);
    @(posedge clk);
    #1;

    single_op(128'd1, 128'd2, 1'b0, "a1_b2");
    single_op(ONES, 128'd0, 1'b1, "propagate");
    single_op(ONES, 128'd1, 1'b0, "generate");
    single_op(128'h00FF_FFFF, 128'd1, 1'b0, "gen24");

    // Backpressure: capacity, then release and in-order drain.
    for (int i = 0; i < 6; i++) begin
      a_arr[i] = rnd128(); b_arr[i] = rnd128(); c_arr[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (n < 6) begin
        offer(a_arr[n], b_arr[n], c_arr[n], took);
        if (took) n++;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("bp_accepted", 129'(n), 129'd4);
    check_eq("bp_in_ready", {128'd0, in_ready}, 129'd0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && n < 6; cyc++) begin
      offer(a_arr[n], b_arr[n], c_arr[n], took);
      if (took) n++;
    end
    check_eq("bp_all_sent", 129'(n), 129'd6);
    repeat (8) @(posedge clk);
    #1;
    check_eq("bp_drained", 129'(exp_q.size()), 129'd0);

    // Streaming at full rate.
    max_run = 0;
    for (int i = 0; i < 20; i++) drive_op(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    repeat (8) @(posedge clk);
    #1;
    check_eq("stream_run", 129'(max_run), 129'd20);
    check_eq("stream_drained", 129'(exp_q.size()), 129'd0);

    // Random out_ready toggling.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) drive_op(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("toggle_drained", 129'(exp_q.size()), 129'd0);

    // Reset with operations in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_op(rnd128(), rnd128(), 1'b0);
    @(posedge clk);
    #1;
    check_eq("rst_pre_valid", {128'd0, out_valid}, 129'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", {128'd0, out_valid}, 129'd0);
    check_eq("rst_async_ready", {128'd0, in_ready}, 129'd0);
    check_eq("rst_async_data", {cout, sum}, 129'd0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_idle", {128'd0, out_valid}, 129'd0);
      if (i == 0) check_eq("post_rst_ready", {128'd0, in_ready}, 129'd1);
    end
    @(posedge clk);
    #1;
    single_op(rnd128(), rnd128(), 1'b1, "post_rst");
    check_eq("final_drained", 129'(exp_q.size()), 129'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
